// File: rtl/water_tank_pkg.sv
// Shared types and default constants for the irrigation reservoir model.
// Build option: define SENSOR_FAULT_EN to add the fault_sel sensor override.
package water_tank_pkg;

  localparam int DEF_LEVEL_W        = 8;
  localparam int DEF_CAPACITY       = 200;
  localparam int DEF_INIT_LEVEL     = 100;
  localparam int DEF_LOW_TH         = 40;
  localparam int DEF_MID_TH         = 100;
  localparam int DEF_HIGH_TH        = 180;
  localparam int DEF_FILL_RATE      = 4;
  localparam int DEF_SPRINKLER_RATE = 3;
  localparam int DEF_DRIPPER_RATE   = 1;
  localparam int DEF_TICK_DIV       = 1000;

  typedef logic [DEF_LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {
    FAULT_NONE        = 2'd0,
    FAULT_LOW_STUCK0  = 2'd1,
    FAULT_MID_ONLY    = 2'd2,
    FAULT_HIGH_STUCK1 = 2'd3
  } fault_sel_e;

  // Thermometer-coded sensor lines as seen by the controller.
  typedef struct packed {
    logic high;
    logic mid;
    logic low;
  } sensors_t;

  // Each line is asserted while the level is at or above its threshold,
  // which keeps the pattern thermometer-legal for ordered thresholds.
  function automatic sensors_t senseLevel(input int lvl, input int lowTh,
                                          input int midTh, input int highTh);
    sensors_t s;
    s.low  = (lvl >= lowTh);
    s.mid  = (lvl >= midTh);
    s.high = (lvl >= highTh);
    return s;
  endfunction

  // Overlays a stuck-at pattern on top of healthy sensor readings so the
  // controller's alarm path can be exercised.
  function automatic sensors_t applyFault(input sensors_t s, input fault_sel_e sel);
    sensors_t f;
    f = s;
    case (sel)
      FAULT_LOW_STUCK0:  f.low = 1'b0;
      FAULT_MID_ONLY: begin
        f.low = 1'b0;
        f.mid = 1'b1;
      end
      FAULT_HIGH_STUCK1: f.high = 1'b1;
      default:           f = s;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/water_tank_model_tick_prescaler.sv
// Free-running tick generator: pulses once every DIV enabled cycles and
// holds its count while disabled.
module tick_prescaler
  import water_tank_pkg::*;
#(
  parameter int DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          atLast;

  assign atLast = (count_q == LAST);

  // Advance and wrap the count only while enabled; otherwise freeze it.
  always_comb begin
    count_d = count_q;
    if (enable) begin
      count_d = atLast ? '0 : count_q + CW'(1);
    end
  end

  // Count register; reset discards any partially elapsed tick period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = enable & atLast;

endmodule

// File: rtl/water_tank_model.sv
// Behavioural irrigation reservoir: integrates actuator commands into a
// level, drives thermometer sensors and raises sticky overflow/dry flags.
// Build option: define SENSOR_FAULT_EN to add the fault_sel sensor override.
module water_tank_model
  import water_tank_pkg::*;
#(
  parameter int LEVEL_W        = DEF_LEVEL_W,
  parameter int CAPACITY       = DEF_CAPACITY,
  parameter int INIT_LEVEL     = DEF_INIT_LEVEL,
  parameter int LOW_TH         = DEF_LOW_TH,
  parameter int MID_TH         = DEF_MID_TH,
  parameter int HIGH_TH        = DEF_HIGH_TH,
  parameter int FILL_RATE      = DEF_FILL_RATE,
  parameter int SPRINKLER_RATE = DEF_SPRINKLER_RATE,
  parameter int DRIPPER_RATE   = DEF_DRIPPER_RATE,
  parameter int TICK_DIV       = DEF_TICK_DIV
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               run,
  input  logic               clear_flags,
  input  logic               water_supply_valvule,
  input  logic               splinker_bomb,
  input  logic               dripper_valvule,
`ifdef SENSOR_FAULT_EN
  input  logic [1:0]         fault_sel,
`endif
  output logic               low_water_level,
  output logic               mid_water_level,
  output logic               high_water_level,
  output logic [LEVEL_W-1:0] level,
  output logic               tick,
  output logic               overflow,
  output logic               dry
);

  // Two guard bits give room for a sign and for overshoot above CAPACITY.
  localparam int RW = LEVEL_W + 2;
  typedef logic signed [RW-1:0] raw_t;

  localparam raw_t               CAP_RAW  = raw_t'(CAPACITY);
  localparam logic [LEVEL_W-1:0] CAP_LVL  = LEVEL_W'(CAPACITY);
  localparam logic [LEVEL_W-1:0] INIT_LVL = LEVEL_W'(INIT_LEVEL);

  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_d;
  logic               overflow_q;
  logic               overflow_d;
  logic               dry_q;
  logic               dry_d;
  sensors_t           sensors_q;
  sensors_t           sensors_d;
  sensors_t           sensorsOut;
  logic               tickPulse;
  raw_t               delta;
  raw_t               raw;

  tick_prescaler #(
    .DIV(TICK_DIV)
  ) u_prescaler (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (run),
    .tick   (tickPulse)
  );

  // Net all active commands into one signed change; fill and drain have no
  // priority over each other.
  always_comb begin
    delta = '0;
    if (water_supply_valvule) begin
      delta = delta + raw_t'(FILL_RATE);
    end
    if (splinker_bomb) begin
      delta = delta - raw_t'(SPRINKLER_RATE);
    end
    if (dripper_valvule) begin
      delta = delta - raw_t'(DRIPPER_RATE);
    end
    raw = $signed({2'b00, level_q}) + delta;
  end

  // Clamp the proposed level into 0..CAPACITY on a tick and flag any
  // attempt to leave that range; a flag being set outranks a clear request.
  always_comb begin
    level_d    = level_q;
    overflow_d = overflow_q;
    dry_d      = dry_q;
    if (clear_flags) begin
      overflow_d = 1'b0;
      dry_d      = 1'b0;
    end
    if (tickPulse) begin
      if (raw[RW-1]) begin
        level_d = '0;
        dry_d   = 1'b1;
      end else if (raw > CAP_RAW) begin
        level_d    = CAP_LVL;
        overflow_d = 1'b1;
      end else begin
        level_d = raw[LEVEL_W-1:0];
      end
    end
  end

  // Sensors follow the stored level, so they trail a level change by a cycle.
  always_comb begin
    sensors_d = senseLevel(int'(level_q), LOW_TH, MID_TH, HIGH_TH);
  end

  // Level, flags and sensor registers; sensors wake up consistent with the
  // initial level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q    <= INIT_LVL;
      overflow_q <= 1'b0;
      dry_q      <= 1'b0;
      sensors_q  <= senseLevel(INIT_LEVEL, LOW_TH, MID_TH, HIGH_TH);
    end else begin
      level_q    <= level_d;
      overflow_q <= overflow_d;
      dry_q      <= dry_d;
      sensors_q  <= sensors_d;
    end
  end

`ifdef SENSOR_FAULT_EN
  assign sensorsOut = applyFault(sensors_q, fault_sel_e'(fault_sel));
`else
  assign sensorsOut = sensors_q;
`endif

  assign low_water_level  = sensorsOut.low;
  assign mid_water_level  = sensorsOut.mid;
  assign high_water_level = sensorsOut.high;
  assign level            = level_q;
  assign tick             = tickPulse;
  assign overflow         = overflow_q;
  assign dry              = dry_q;

endmodule

// File: tb/tb_water_tank_model.sv
// Directed bench for water_tank_model with a 4-cycle tick period.
// Fault-overlay steps are compiled in when SENSOR_FAULT_EN is defined.
module tb_water_tank_model;

  logic       clock;
  logic       reset_n;
  logic       run;
  logic       clear_flags;
  logic       water_supply_valvule;
  logic       splinker_bomb;
  logic       dripper_valvule;
`ifdef SENSOR_FAULT_EN
  logic [1:0] fault_sel;
`endif
  logic       low_water_level;
  logic       mid_water_level;
  logic       high_water_level;
  logic [7:0] level;
  logic       tick;
  logic       overflow;
  logic       dry;

  int vectors;
  int miscompares;

  water_tank_model #(
    .TICK_DIV(4)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .run                 (run),
    .clear_flags         (clear_flags),
    .water_supply_valvule(water_supply_valvule),
    .splinker_bomb       (splinker_bomb),
    .dripper_valvule     (dripper_valvule),
`ifdef SENSOR_FAULT_EN
    .fault_sel           (fault_sel),
`endif
    .low_water_level     (low_water_level),
    .mid_water_level     (mid_water_level),
    .high_water_level    (high_water_level),
    .level               (level),
    .tick                (tick),
    .overflow            (overflow),
    .dry                 (dry)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case something upstream never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected summary before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkSensors(input string tag, input logic lo, input logic mi,
                              input logic hi);
    checkOutput({tag, ".low"},  32'(low_water_level),  32'(lo));
    checkOutput({tag, ".mid"},  32'(mid_water_level),  32'(mi));
    checkOutput({tag, ".high"}, 32'(high_water_level), 32'(hi));
  endtask

  task automatic applyStimulus(input logic supply, input logic sprinkler,
                               input logic dripper);
    water_supply_valvule = supply;
    splinker_bomb        = sprinkler;
    dripper_valvule      = dripper;
  endtask

  // Wait (bounded) for a tick, then step past the edge that applies it.
  task automatic stepTick();
    int waited;
    waited = 0;
    while (tick !== 1'b1 && waited < 16) begin
      waitCycles(1);
      waited++;
    end
    checkOutput("tickSeen", 32'(tick), 32'd1);
    waitCycles(1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    run         = 1'b0;
    clear_flags = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef SENSOR_FAULT_EN
    fault_sel = 2'd0;
`endif

    // Reset state
    waitCycles(3);
    checkOutput("rstLevel", 32'(level), 32'd100);
    checkOutput("rstTick", 32'(tick), 32'd0);
    checkOutput("rstOverflow", 32'(overflow), 32'd0);
    checkOutput("rstDry", 32'(dry), 32'd0);
    checkSensors("rstSensors", 1'b1, 1'b1, 1'b0);

    // Idle run: tick on the 4th counted cycle, level unchanged
    reset_n = 1'b1;
    run     = 1'b1;
    waitCycles(2);
    checkOutput("idleTick2", 32'(tick), 32'd0);
    waitCycles(1);
    checkOutput("idleTick3", 32'(tick), 32'd1);
    waitCycles(1);
    checkOutput("idleTickAfter", 32'(tick), 32'd0);
    checkOutput("idleLevel", 32'(level), 32'd100);

    // Fill: 19 ticks to 176, 20th to 180, high sensor lags by one more cycle
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) stepTick();
    checkOutput("fill19Level", 32'(level), 32'd176);
    stepTick();
    checkOutput("fill20Level", 32'(level), 32'd180);
    checkOutput("fill20HighLag", 32'(high_water_level), 32'd0);
    waitCycles(1);
    checkOutput("fill20High", 32'(high_water_level), 32'd1);
    for (int i = 0; i < 5; i++) stepTick();
    checkOutput("capLevel", 32'(level), 32'd200);
    checkOutput("capNoOverflow", 32'(overflow), 32'd0);
    stepTick();
    checkOutput("ovfLevel", 32'(level), 32'd200);
    checkOutput("ovfFlag", 32'(overflow), 32'd1);
    checkOutput("ovfNoDry", 32'(dry), 32'd0);

    // Clear held through an overflowing tick: set wins, then clear takes it
    clear_flags = 1'b1;
    stepTick();
    checkOutput("ovfSetWins", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(1);
    clear_flags = 1'b0;
    checkOutput("ovfCleared", 32'(overflow), 32'd0);

    // Sprinkler alone: 66 ticks of -3 from 200 reaches 2
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 66; i++) stepTick();
    checkOutput("drainLevel", 32'(level), 32'd2);
    checkOutput("drainNoDry", 32'(dry), 32'd0);

    // Sprinkler + dripper from 2: raw -2 clamps to 0 and sets dry
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepTick();
    checkOutput("dryLevel", 32'(level), 32'd0);
    checkOutput("dryFlag", 32'(dry), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkSensors("drySensors", 1'b0, 1'b0, 1'b0);
    clear_flags = 1'b1;
    waitCycles(1);
    clear_flags = 1'b0;
    checkOutput("dryCleared", 32'(dry), 32'd0);
    checkOutput("dryLevelHeld", 32'(level), 32'd0);

    // Refill to 100, then all three commands net to zero
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) stepTick();
    checkOutput("refillLevel", 32'(level), 32'd100);
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) stepTick();
    checkOutput("netZeroLevel", 32'(level), 32'd100);
    checkOutput("netZeroOverflow", 32'(overflow), 32'd0);
    checkOutput("netZeroDry", 32'(dry), 32'd0);
    waitCycles(1);
    checkSensors("netZeroSensors", 1'b1, 1'b1, 1'b0);

    // Pause mid-count at count 2: frozen for 10 cycles, then one cycle left
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    run = 1'b0;
    waitCycles(10);
    checkOutput("pauseTick", 32'(tick), 32'd0);
    checkOutput("pauseLevel", 32'(level), 32'd100);
    run = 1'b1;
    #1;
    checkOutput("resumeTick0", 32'(tick), 32'd0);
    waitCycles(1);
    checkOutput("resumeTick1", 32'(tick), 32'd1);
    checkOutput("resumeLevelPre", 32'(level), 32'd100);
    waitCycles(1);
    checkOutput("resumeLevelPost", 32'(level), 32'd104);

    // Reset mid-count: level back to 100, partial period discarded
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);
    reset_n = 1'b0;
    #1;
    checkOutput("midRstLevel", 32'(level), 32'd100);
    checkOutput("midRstTick", 32'(tick), 32'd0);
    waitCycles(1);
    reset_n = 1'b1;
    waitCycles(1);
    checkOutput("postRstTick1", 32'(tick), 32'd0);
    waitCycles(1);
    checkOutput("postRstTick2", 32'(tick), 32'd0);
    waitCycles(1);
    checkOutput("postRstTick3", 32'(tick), 32'd1);
    waitCycles(1);
    checkOutput("postRstLevel", 32'(level), 32'd100);
    checkSensors("postRstSensors", 1'b1, 1'b1, 1'b0);

`ifdef SENSOR_FAULT_EN
    // Fault overlay on level 100 (healthy pattern 1/1/0)
    fault_sel = 2'd2;
    #1;
    checkSensors("faultMidOnly", 1'b0, 1'b1, 1'b0);
    fault_sel = 2'd1;
    #1;
    checkSensors("faultLowStuck0", 1'b0, 1'b1, 1'b0);
    fault_sel = 2'd3;
    #1;
    checkSensors("faultHighStuck1", 1'b1, 1'b1, 1'b1);
    fault_sel = 2'd0;
    #1;
    checkSensors("faultNone", 1'b1, 1'b1, 1'b0);
    checkOutput("faultLevel", 32'(level), 32'd100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/water_tank_model.md
# water_tank_model

Cycle-level behavioural model of the irrigation reservoir, built as synthesizable RTL for FPGA demos and closed-loop benches. It consumes the actuator commands produced by the irrigation controller (supply valve, sprinkler pump, dripper valve). It integrates them into a water level and drives back the thermometer-coded low/mid/high level sensor lines the controller reads. An optional fault injector forces illegal sensor patterns to exercise the controller's alarm path.

## Interface
- LEVEL_W, 8: width of the level accumulator.
- CAPACITY, 200: maximum level; must be < 2**LEVEL_W.
- INIT_LEVEL, 100: level after reset.
- LOW_TH / MID_TH / HIGH_TH, 40 / 100 / 180: sensor thresholds, LOW_TH < MID_TH < HIGH_TH ≤ CAPACITY.
- FILL_RATE / SPRINKLER_RATE / DRIPPER_RATE, 4 / 3 / 1: level units per tick.
- TICK_DIV, 1000: clock cycles per simulation tick, ≥ 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  tick prescaler enable; when low, the prescaler and level freeze.
- clear_flags  in  1  synchronous clear of the sticky flags.
- water_supply_valvule  in  1  filling active.
- splinker_bomb  in  1  sprinkler draining active.
- dripper_valvule  in  1  dripper draining active.
- low_water_level / mid_water_level / high_water_level  out  1 each  sensor asserted while level ≥ the respective threshold.
- level  out  LEVEL_W  current level.
- tick  out  1  one-cycle pulse marking a level update.
- overflow  out  1  sticky flag: fill was attempted beyond CAPACITY.
- dry  out  1  sticky flag: drain was attempted below 0.
- fault_sel  in  2  (SENSOR_FAULT_EN only) 0 none, 1 low stuck-0, 2 mid stuck-1 with low 0, 3 high stuck-1.

## Operation
- Prescaler counts 0..TICK_DIV-1 while run=1, then wraps. tick=1 on the cycle the count equals TICK_DIV-1. With TICK_DIV=1, tick is high every cycle while run=1.
- On a tick cycle: delta = +FILL_RATE·supply − SPRINKLER_RATE·splinker − DRIPPER_RATE·dripper.
- raw = level + delta, computed signed at LEVEL_W+2 bits.
- level ← clamp(raw, 0, CAPACITY).
- If raw > CAPACITY, overflow ← 1. If raw < 0, dry ← 1.
- Simultaneous fill and drain commands net into the single delta. There is no priority between them.
- clear_flags=1 clears both flags. If clear_flags=1 on the same cycle a flag sets, the set wins.
- Sensor outputs are registered from the updated level: each output is (level ≥ threshold). The result is always thermometer-legal when no fault is injected.
- Commands sampled on non-tick cycles have no effect.

## Timing
- Reset (asynchronous assert, synchronous deassert at the bench level) sets:
  - prescaler 0, level INIT_LEVEL, tick 0, overflow 0, dry 0.
  - sensor registers to the values derived from INIT_LEVEL (defaults: low=1, mid=1, high=0).
- First tick occurs TICK_DIV cycles after the first run=1 edge following reset.
- level updates on the clock edge ending the tick cycle. Sensors and fault overlay update one cycle later (latency 2 from tick to sensor change).
- Dropping run freezes the prescaler value; raising run resumes counting from the frozen value.
- Reset mid-count discards the partial tick.

## Configuration
- SENSOR_FAULT_EN:
  - Defined: the fault_sel port exists. A nonzero value overrides the registered sensor outputs with the encoded stuck pattern; the override is combinational on the registered sensors. level and the flags are unaffected.
  - Undefined: the port is absent and the sensors always reflect level.

## Structure
- Package water_tank_pkg holds:
  - default threshold, rate and capacity constants;
  - level_t (logic [LEVEL_W-1:0] at default width);
  - fault_sel_e enum: FAULT_NONE, FAULT_LOW_STUCK0, FAULT_MID_ONLY, FAULT_HIGH_STUCK1.
- One sub-module, tick_prescaler (parameter DIV; ports clock, reset_n, enable, tick). The level integrator, flags and sensor registers stay in the top.

## Test plan
- Reset with defaults, TICK_DIV=4, run=1, no actuators -> level stays 100; sensors low=1, mid=1, high=0; tick every 4th cycle.
- Supply on, from level 100 -> +4 per tick; high_water_level rises 2 cycles after the tick that makes level 180 (20th tick); at 200, the next tick sets overflow and level holds 200.
- Sprinkler + dripper on from level 2 -> next tick raw = −2, level 0, dry=1, low=0; clear_flags then drops dry.
- Supply + sprinkler + dripper together from 100 -> net 0, level stays 100.
- run low for 10 cycles mid-count -> no tick and level frozen; tick resumes with the remaining count.
- SENSOR_FAULT_EN, fault_sel=2 at level 100 -> outputs low=0, mid=1, high=0; fault_sel=0 restores low=1, mid=1, high=0.
